seg_display_arbiter: RTL
========================

# seg_display_arbiter

Round-robin scheduler that shares the single 7-segment display output between four digit requesters. Each granted requester owns the display for a fixed hold window; requests are served fairly and the display contents are decoded from the winner's 4-bit value. It sits between the counter/game logic blocks and the 8-bit `io_out` pins: `segments` maps to `io_out[6:0]` and `busy` to `io_out[7]`.

## Interface

- `HOLD_CYCLES`, 100: display hold window per grant in clock cycles; legal range 1..65535.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low; clears all state immediately on assertion.
- `req`  input  4  level request per requester; bit i = requester i.
- `digit0`..`digit3`  input  4 each  hex value offered by requester i; sampled only at grant.
- `ack`  output  4  one-cycle pulse on bit i in the cycle after requester i's value is latched.
- `grant`  output  4  one-hot owner of the display; 0 when idle.
- `segments`  output  7  active-high, bit0=a … bit6=g.
- `busy`  output  1  high while in SHOW.

## Operation

- States: IDLE, SHOW. Counter `cnt` width $clog2(HOLD_CYCLES)+1; round-robin pointer `last` (2 bits).
- Arbitration point: any cycle with state==IDLE, or state==SHOW and cnt==0.
- At an arbitration point with req!=0: winner = first set bit of `req` scanning from `last+1` upward, mod 4. Next edge: state←SHOW, grant←onehot(winner), latch digit_winner, last←winner, cnt←HOLD_CYCLES-1, ack[winner]←1.
- At an arbitration point with req==0: next edge state←IDLE, grant←0, cnt←0.
- In SHOW with cnt!=0: cnt decrements by 1 per cycle; `req` and `digitN` ignored; latched digit stable.
- `ack` is never high for more than one consecutive cycle per grant. A requester still holding `req` after its ack re-enters arbitration and is served again only after every other pending requester.
- Back-to-back grants: no IDLE bubble when a request is pending at cnt==0.
- Decode: 0→3F,1→06,2→5B,3→4F,4→66,5→6D,6→7D,7→07,8→7F,9→6F,A→77,b→7C,C→39,d→5E,E→79,F→71 (hex, 7-bit).
- `busy` = (state==SHOW); `segments` is registered decode of the latched digit (no combinational path from `req`/`digitN`).

## Timing

- Reset values: state IDLE, grant 0, ack 0, busy 0, segments 0, cnt 0, last 3 (so requester 0 wins first), display-valid flag 0.
- Reset asserted mid-SHOW: outputs take reset values asynchronously; after release first arbitration on the first edge with state IDLE.
- Latency: req rising in IDLE at edge k-sample → grant/ack/busy/segments valid after edge k+1 (one cycle).
- Window: grant held exactly HOLD_CYCLES cycles; with HOLD_CYCLES=1 every cycle is an arbitration point.
- Simultaneous requests: resolved purely by pointer; all four high rotate 0,1,2,3,0….
- `req` dropped while owner in SHOW: no effect; window completes.

## Configuration

- `SEG_ARB_BLANK_EN` defined: in IDLE `segments`=0 (display blank).
- Not defined: in IDLE `segments` keeps the last latched digit's pattern; before the first grant after reset it is 0.
- `grant`, `busy`, `ack` identical in both builds.

## Test plan

- Reset: drive rst=0 with random inputs → segments=0, grant=0, ack=0, busy=0; release, req=0 → stays IDLE.
- Single request: req=4'b0100, digit2=8 → one cycle later grant=0100, ack=0100 for 1 cycle, segments=7F, busy=1 for 100 cycles, then IDLE.
- Fairness: req=4'b1111 held, digits 1,2,3,4 → grants 0,1,2,3,0 each exactly 100 cycles, segments 06,5B,4F,66, no bubbles.
- Digit change during SHOW: digit0 switches 1→F mid-window → segments stays 06 until window end.
- Async reset mid-SHOW at cycle 50 → outputs zero without a clock edge; next grant after release goes to requester 0.
- Idle display: after one grant of digit A with req dropped → IDLE segments=00 with SEG_ARB_BLANK_EN, 77 without.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 7-segment display: four requesters, fixed hold window per grant.
// Build option SEG_ARB_BLANK_EN: blank the display while idle instead of keeping the last digit.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [3:0] ack,
    output logic [3:0] grant,
    output logic [6:0] segments,
    output logic       busy
);

    localparam int CW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Hex digit to active-high a..g pattern (bit0 = a).
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            4'hF:    p = 7'h71;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // First set request scanning upward from the slot after the previous owner;
    // the previous owner itself is considered last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic       found;
        logic [1:0] win;
        win   = l;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = l + k[1:0];
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    state_t        state_r, state_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [1:0]    last_r, last_n;
    logic [3:0]    grant_r, grant_n;
    logic [3:0]    ack_r, ack_n;
    logic [3:0]    digit_r, digit_n;
    logic          valid_r, valid_n;
    logic [6:0]    seg_r, seg_n;
    logic          arb_s;
    logic [1:0]    win_s;
    logic [3:0]    win_digit_s;

    assign arb_s = (state_r == IDLE) || (cnt_r == CNT_ZERO);
    assign win_s = rr_pick(req, last_r);

    // Select the value offered by the arbitration winner.
    always_comb begin
        win_digit_s = 4'h0;
        case (win_s)
            2'd0:    win_digit_s = digit0;
            2'd1:    win_digit_s = digit1;
            2'd2:    win_digit_s = digit2;
            2'd3:    win_digit_s = digit3;
            default: win_digit_s = 4'h0;
        endcase
    end

    // Next-state, grant/ack and latched-digit logic.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        last_n  = last_r;
        grant_n = grant_r;
        ack_n   = 4'b0000;
        digit_n = digit_r;
        valid_n = valid_r;
        if (arb_s) begin
            if (req != 4'b0000) begin
                state_n = SHOW;
                cnt_n   = CNT_LOAD;
                last_n  = win_s;
                grant_n = 4'b0001 << win_s;
                ack_n   = 4'b0001 << win_s;
                digit_n = win_digit_s;
                valid_n = 1'b1;
            end else begin
                state_n = IDLE;
                cnt_n   = CNT_ZERO;
                grant_n = 4'b0000;
            end
        end else begin
            cnt_n = cnt_r - CNT_ONE;
        end
    end

    // Segment pattern is computed from the next latched digit so it lines up with grant.
    always_comb begin
        seg_n = 7'h00;
`ifdef SEG_ARB_BLANK_EN
        if (state_n == SHOW) begin
            seg_n = seg_decode(digit_n);
        end else begin
            seg_n = 7'h00;
        end
`else
        if (valid_n) begin
            seg_n = seg_decode(digit_n);
        end else begin
            seg_n = 7'h00;
        end
`endif
    end

    // State and output registers; pointer resets to 3 so requester 0 is served first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            last_r  <= 2'd3;
            grant_r <= 4'b0000;
            ack_r   <= 4'b0000;
            digit_r <= 4'h0;
            valid_r <= 1'b0;
            seg_r   <= 7'h00;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            last_r  <= last_n;
            grant_r <= grant_n;
            ack_r   <= ack_n;
            digit_r <= digit_n;
            valid_r <= valid_n;
            seg_r   <= seg_n;
        end
    end

    assign ack      = ack_r;
    assign grant    = grant_r;
    assign segments = seg_r;
    assign busy     = (state_r == SHOW);

endmodule
